// File: rtl/seqdect_param.sv
// rtl/seqdect_param.sv - parametrised serial pattern detector with overlap select and saturating match counter
module seqdect_param #(
    parameter int PAT_W = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             prtx,
    input  logic             prtx_vld,
    input  logic [PAT_W-1:0] cfg_pat,
    input  logic             cfg_ovl,
    input  logic             clr,
    output logic             prtz,
    output logic [CNT_W-1:0] match_cnt,
    output logic             cnt_sat
);

    localparam int FW = $clog2(PAT_W + 1);
    localparam logic [FW-1:0] FULL = FW'(PAT_W);

    logic [PAT_W-1:0] hist;
    logic [PAT_W-1:0] nhist;
    logic [FW-1:0]    fill;
    logic [FW-1:0]    nfill;
    logic             match;

    // fill counts valid bits since the last restart point, so a match needs PAT_W of them
    always_comb begin
        nhist = {hist[PAT_W-2:0], prtx};
        nfill = (fill == FULL) ? FULL : fill + 1'b1;
        match = (nfill == FULL) && (nhist == cfg_pat);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            hist      <= '0;
            fill      <= '0;
            prtz      <= 1'b0;
            match_cnt <= '0;
        end else if (clr) begin
            hist      <= '0;
            fill      <= '0;
            prtz      <= 1'b0;
            match_cnt <= '0;
        end else if (prtx_vld) begin
            hist <= nhist;
            fill <= (match && !cfg_ovl) ? '0 : nfill;
            prtz <= match;
            if (match && !(&match_cnt)) begin
                match_cnt <= match_cnt + 1'b1;
            end
        end else begin
            prtz <= 1'b0;
        end
    end

    assign cnt_sat = &match_cnt;

endmodule

// File: tb/tb_seqdect_param.sv
// tb/tb_seqdect_param.sv - self-checking bench for seqdect_param against a bit-stream model
module tb_seqdect_param;

    logic       clk;
    logic       rst;
    logic       prtx;
    logic       prtx_vld;
    logic       cfg_ovl;
    logic       clr;
    logic [3:0] cfg_pat4;
    logic [1:0] cfg_pat2;

    logic       prtz4;
    logic [7:0] match_cnt4;
    logic       cnt_sat4;
    logic       prtz2;
    logic [1:0] match_cnt2;
    logic       cnt_sat2;

    int tests;
    int fails;
    int pulses4;
    int pulses2;

    seqdect_param #(.PAT_W(4), .CNT_W(8)) dut4 (
        .clk(clk), .rst(rst), .prtx(prtx), .prtx_vld(prtx_vld),
        .cfg_pat(cfg_pat4), .cfg_ovl(cfg_ovl), .clr(clr),
        .prtz(prtz4), .match_cnt(match_cnt4), .cnt_sat(cnt_sat4)
    );

    seqdect_param #(.PAT_W(2), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .prtx(prtx), .prtx_vld(prtx_vld),
        .cfg_pat(cfg_pat2), .cfg_ovl(cfg_ovl), .clr(clr),
        .prtz(prtz2), .match_cnt(match_cnt2), .cnt_sat(cnt_sat2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Model: the valid bits seen since reset/clear, and how many have arrived since the last restart point
    bit q4[$];
    bit q2[$];
    int since4, since2;
    int mcnt4, mcnt2;
    bit mz4, mz2;

    function automatic bit tail_match(input bit q[$], input int pw, input logic [15:0] pat);
        for (int i = 0; i < pw; i++) begin
            if (q[q.size() - pw + i] != pat[pw - 1 - i]) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic model_edge();
        bit m;
        if (!rst || clr) begin
            q4.delete(); q2.delete();
            since4 = 0; since2 = 0;
            mcnt4 = 0; mcnt2 = 0;
            mz4 = 0; mz2 = 0;
        end else if (prtx_vld) begin
            q4.push_back(prtx); q2.push_back(prtx);
            if (q4.size() > 16) void'(q4.pop_front());
            if (q2.size() > 16) void'(q2.pop_front());
            since4++; since2++;
            m = (since4 >= 4) && tail_match(q4, 4, 16'(cfg_pat4));
            mz4 = m;
            if (m) begin
                if (mcnt4 < 255) mcnt4++;
                if (!cfg_ovl) since4 = 0;
            end
            m = (since2 >= 2) && tail_match(q2, 2, 16'(cfg_pat2));
            mz2 = m;
            if (m) begin
                if (mcnt2 < 3) mcnt2++;
                if (!cfg_ovl) since2 = 0;
            end
        end else begin
            mz4 = 0; mz2 = 0;
        end
    endtask

    initial begin
        mz4 = 0; mz2 = 0; mcnt4 = 0; mcnt2 = 0; since4 = 0; since2 = 0;
        forever begin
            @(posedge clk);
            model_edge();
        end
    end

    // Per-cycle comparison, sampled on the falling edge
    initial begin
        forever begin
            @(negedge clk);
            chk("prtz4", int'(prtz4), int'(mz4));
            chk("match_cnt4", int'(match_cnt4), mcnt4);
            chk("cnt_sat4", int'(cnt_sat4), int'(mcnt4 == 255));
            chk("prtz2", int'(prtz2), int'(mz2));
            chk("match_cnt2", int'(match_cnt2), mcnt2);
            chk("cnt_sat2", int'(cnt_sat2), int'(mcnt2 == 3));
            if (prtz4 === 1'b1) pulses4++;
            if (prtz2 === 1'b1) pulses2++;
        end
    end

    task automatic send(input logic b);
        prtx = b;
        prtx_vld = 1'b1;
        @(posedge clk); #1;
        prtx_vld = 1'b0;
        prtx = 1'bx;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            prtx = 1'bx;
            prtx_vld = 1'b0;
            @(posedge clk); #1;
        end
    endtask

    task automatic do_clr();
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        pulses4 = 0;
        pulses2 = 0;
    endtask

    task automatic send_seq(input logic [15:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) send(bits[i]);
    endtask

    initial begin
        tests = 0; fails = 0; pulses4 = 0; pulses2 = 0;
        rst = 1'b0; clr = 1'b0; prtx = 1'b0; prtx_vld = 1'b0;
        cfg_ovl = 1'b1; cfg_pat4 = 4'b1010; cfg_pat2 = 2'b11;

        // Reset held with random stimulus
        for (int i = 0; i < 6; i++) begin
            prtx = 1'($urandom_range(0, 1));
            prtx_vld = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            chk("rst_prtz", int'(prtz4), 0);
            chk("rst_cnt", int'(match_cnt4), 0);
            chk("rst_sat", int'(cnt_sat2), 0);
        end
        prtx_vld = 1'b0;
        rst = 1'b1;
        idle(1);

        // Overlap 1010 on 1,0,1,0,1,0
        do_clr();
        send_seq(16'b101010, 6);
        idle(2);
        chk("ovl_pulses", pulses4, 2);
        chk("ovl_cnt", int'(match_cnt4), 2);
        chk("ovl_model", mcnt4, 2);

        // Non-overlap on 1,0,1,0,1,0,1,0
        cfg_ovl = 1'b0;
        do_clr();
        send_seq(16'b10101010, 8);
        idle(2);
        chk("novl_pulses", pulses4, 2);
        chk("novl_cnt", int'(match_cnt4), 2);
        chk("novl_model", mcnt4, 2);

        // Valid gaps with X data
        cfg_ovl = 1'b1;
        do_clr();
        send(1'b1); send(1'b0);
        idle(3);
        send(1'b1); send(1'b0);
        idle(2);
        chk("gap_pulses", pulses4, 1);
        chk("gap_cnt", int'(match_cnt4), 1);

        // Reset mid-sequence
        do_clr();
        send_seq(16'b101, 3);
        rst = 1'b0;
        idle(1);
        rst = 1'b1;
        send_seq(16'b01010, 5);
        idle(2);
        chk("rstmid_pulses", pulses4, 1);
        chk("rstmid_cnt", int'(match_cnt4), 1);

        // Clear mid-sequence with a coincident valid bit that must be dropped
        do_clr();
        send_seq(16'b101, 3);
        clr = 1'b1; prtx = 1'b0; prtx_vld = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0; prtx_vld = 1'b0;
        pulses4 = 0;
        send_seq(16'b01010, 5);
        idle(2);
        chk("clrmid_pulses", pulses4, 1);
        chk("clrmid_cnt", int'(match_cnt4), 1);
        chk("clrmid_model", mcnt4, 1);

        // Saturation: pattern 11 on six ones, CNT_W=2
        cfg_pat4 = 4'b1111;
        do_clr();
        send(1'b1);
        send(1'b1); chk("sat_c1", int'(match_cnt2), 1);
        send(1'b1); chk("sat_c2", int'(match_cnt2), 2);
        chk("sat_nsat", int'(cnt_sat2), 0);
        send(1'b1); chk("sat_c3", int'(match_cnt2), 3);
        chk("sat_on", int'(cnt_sat2), 1);
        send(1'b1); send(1'b1);
        chk("sat_c5", int'(match_cnt2), 3);
        idle(2);
        chk("sat_pulses", pulses2, 5);
        chk("sat_flag", int'(cnt_sat2), 1);
        chk("sat_model", mcnt2, 3);
        chk("all1_pulses4", pulses4, 3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
